// File: rtl/axi_lite_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_arbiter_2to1
// Description : Two-master to one-slave AXI-Lite arbiter, one transaction at a
//               time, round-robin or fixed-priority (M1 wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // master 0 (instruction fetch)
    input  logic [ADDR_W-1:0]     ARADDR_M0,
    input  logic                  ARVALID_M0,
    output logic                  ARREADY_M0,
    output logic [DATA_W-1:0]     RDATA_M0,
    output logic [1:0]            RRESP_M0,
    output logic                  RVALID_M0,
    input  logic                  RREADY_M0,
    input  logic [ADDR_W-1:0]     AWADDR_M0,
    input  logic                  AWVALID_M0,
    output logic                  AWREADY_M0,
    input  logic [DATA_W-1:0]     WDATA_M0,
    input  logic [DATA_W/8-1:0]   WSTRB_M0,
    input  logic                  WVALID_M0,
    output logic                  WREADY_M0,
    output logic [1:0]            BRESP_M0,
    output logic                  BVALID_M0,
    input  logic                  BREADY_M0,
    // master 1 (data access)
    input  logic [ADDR_W-1:0]     ARADDR_M1,
    input  logic                  ARVALID_M1,
    output logic                  ARREADY_M1,
    output logic [DATA_W-1:0]     RDATA_M1,
    output logic [1:0]            RRESP_M1,
    output logic                  RVALID_M1,
    input  logic                  RREADY_M1,
    input  logic [ADDR_W-1:0]     AWADDR_M1,
    input  logic                  AWVALID_M1,
    output logic                  AWREADY_M1,
    input  logic [DATA_W-1:0]     WDATA_M1,
    input  logic [DATA_W/8-1:0]   WSTRB_M1,
    input  logic                  WVALID_M1,
    output logic                  WREADY_M1,
    output logic [1:0]            BRESP_M1,
    output logic                  BVALID_M1,
    input  logic                  BREADY_M1,
    // shared slave
    output logic [ADDR_W-1:0]     ARADDR_S,
    output logic                  ARVALID_S,
    input  logic                  ARREADY_S,
    input  logic [DATA_W-1:0]     RDATA_S,
    input  logic [1:0]            RRESP_S,
    input  logic                  RVALID_S,
    output logic                  RREADY_S,
    output logic [ADDR_W-1:0]     AWADDR_S,
    output logic                  AWVALID_S,
    input  logic                  AWREADY_S,
    output logic [DATA_W-1:0]     WDATA_S,
    output logic [DATA_W/8-1:0]   WSTRB_S,
    output logic                  WVALID_S,
    input  logic                  WREADY_S,
    input  logic [1:0]            BRESP_S,
    input  logic                  BVALID_S,
    output logic                  BREADY_S
);

    localparam int         c_STRB_W  = DATA_W / 8;
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_ADDR = 3'd1;
    localparam logic [2:0] c_RD_DATA = 3'd2;
    localparam logic [2:0] c_WR_ADDR = 3'd3;
    localparam logic [2:0] c_WR_RESP = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic                r_g;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_STRB_W-1:0] r_wstrb;
    logic                r_aw_done;
    logic                r_w_done;

    logic w_wr_req0, w_wr_req1, w_req0, w_req1;
    logic w_pick, w_pick_wr, w_grant, w_grant_out;
    logic w_rready_g, w_bready_g;

    assign w_wr_req0 = AWVALID_M0 & WVALID_M0;
    assign w_wr_req1 = AWVALID_M1 & WVALID_M1;
    assign w_req0    = ARVALID_M0 | w_wr_req0;
    assign w_req1    = ARVALID_M1 | w_wr_req1;

    // On a tie the master that did not win last time goes, unless M1 is pinned.
    assign w_pick      = (w_req0 & w_req1) ? ((FIXED_PRIO != 0) ? 1'b1 : ~r_last) : w_req1;
    assign w_pick_wr   = w_pick ? w_wr_req1 : w_wr_req0;
    assign w_grant     = (r_state == c_IDLE) & (w_req0 | w_req1);
    // Master-side readies must drop the instant reset asserts, not at the next edge.
    assign w_grant_out = w_grant & ~ARESET;

    assign ARREADY_M0 = w_grant_out & ~w_pick & ~w_pick_wr;
    assign ARREADY_M1 = w_grant_out &  w_pick & ~w_pick_wr;
    assign AWREADY_M0 = w_grant_out & ~w_pick &  w_pick_wr;
    assign AWREADY_M1 = w_grant_out &  w_pick &  w_pick_wr;
    assign WREADY_M0  = AWREADY_M0;
    assign WREADY_M1  = AWREADY_M1;

    assign RDATA_M0 = RDATA_S;
    assign RDATA_M1 = RDATA_S;
    assign RRESP_M0 = RRESP_S;
    assign RRESP_M1 = RRESP_S;
    assign BRESP_M0 = BRESP_S;
    assign BRESP_M1 = BRESP_S;

    assign ARADDR_S = r_addr;
    assign AWADDR_S = r_addr;
    assign WDATA_S  = r_wdata;
    assign WSTRB_S  = r_wstrb;

    assign w_rready_g = r_g ? RREADY_M1 : RREADY_M0;
    assign w_bready_g = r_g ? BREADY_M1 : BREADY_M0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= c_IDLE;
            r_g       <= 1'b0;
            r_last    <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_g       <= w_pick;
                r_last    <= w_pick;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (w_pick_wr) begin
                    r_addr  <= w_pick ? AWADDR_M1 : AWADDR_M0;
                    r_wdata <= w_pick ? WDATA_M1 : WDATA_M0;
                    r_wstrb <= w_pick ? WSTRB_M1 : WSTRB_M0;
                end else begin
                    r_addr  <= w_pick ? ARADDR_M1 : ARADDR_M0;
                end
            end else if (r_state == c_WR_ADDR) begin
                r_aw_done <= r_aw_done | AWREADY_S;
                r_w_done  <= r_w_done | WREADY_S;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        ARVALID_S    = 1'b0;
        RREADY_S     = 1'b0;
        AWVALID_S    = 1'b0;
        WVALID_S     = 1'b0;
        BREADY_S     = 1'b0;
        RVALID_M0    = 1'b0;
        RVALID_M1    = 1'b0;
        BVALID_M0    = 1'b0;
        BVALID_M1    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_grant) begin
                    w_state_next = w_pick_wr ? c_WR_ADDR : c_RD_ADDR;
                end
            end
            c_RD_ADDR: begin
                ARVALID_S = 1'b1;
                if (ARREADY_S) begin
                    w_state_next = c_RD_DATA;
                end
            end
            c_RD_DATA: begin
                RREADY_S  = w_rready_g;
                RVALID_M0 = ~r_g & RVALID_S;
                RVALID_M1 =  r_g & RVALID_S;
                if (RVALID_S && w_rready_g) begin
                    w_state_next = c_IDLE;
                end
            end
            c_WR_ADDR: begin
                AWVALID_S = ~r_aw_done;
                WVALID_S  = ~r_w_done;
                if ((r_aw_done || AWREADY_S) && (r_w_done || WREADY_S)) begin
                    w_state_next = c_WR_RESP;
                end
            end
            c_WR_RESP: begin
                BREADY_S  = w_bready_g;
                BVALID_M0 = ~r_g & BVALID_S;
                BVALID_M1 =  r_g & BVALID_S;
                if (BVALID_S && w_bready_g) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_arbiter_2to1
// Description : Randomized bench for axi_lite_arbiter_2to1 with a
//               transaction-level reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_arbiter_2to1;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int FIXED = 0;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic [AW-1:0] ARADDR_M0, ARADDR_M1, AWADDR_M0, AWADDR_M1, ARADDR_S, AWADDR_S;
    logic [DW-1:0] RDATA_M0, RDATA_M1, WDATA_M0, WDATA_M1, RDATA_S, WDATA_S;
    logic [SW-1:0] WSTRB_M0, WSTRB_M1, WSTRB_S;
    logic [1:0]    RRESP_M0, RRESP_M1, BRESP_M0, BRESP_M1, RRESP_S, BRESP_S;
    logic ARVALID_M0, ARREADY_M0, RVALID_M0, RREADY_M0, AWVALID_M0, AWREADY_M0;
    logic WVALID_M0, WREADY_M0, BVALID_M0, BREADY_M0;
    logic ARVALID_M1, ARREADY_M1, RVALID_M1, RREADY_M1, AWVALID_M1, AWREADY_M1;
    logic WVALID_M1, WREADY_M1, BVALID_M1, BREADY_M1;
    logic ARVALID_S, ARREADY_S, RVALID_S, RREADY_S, AWVALID_S, AWREADY_S;
    logic WVALID_S, WREADY_S, BVALID_S, BREADY_S;

    axi_lite_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(FIXED)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARADDR_M0(ARADDR_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .AWADDR_M0(AWADDR_M0), .AWVALID_M0(AWVALID_M0), .AWREADY_M0(AWREADY_M0),
        .WDATA_M0(WDATA_M0), .WSTRB_M0(WSTRB_M0), .WVALID_M0(WVALID_M0), .WREADY_M0(WREADY_M0),
        .BRESP_M0(BRESP_M0), .BVALID_M0(BVALID_M0), .BREADY_M0(BREADY_M0),
        .ARADDR_M1(ARADDR_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .AWADDR_M1(AWADDR_M1), .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
        .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
        .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
        .ARADDR_S(ARADDR_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWADDR_S(AWADDR_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // master intent, knobs
    logic          m_rd[2], m_wr[2];
    logic [31:0]   m_ra[2], m_wa[2], m_wd[2];
    logic [3:0]    m_ws[2];
    int            rr_mode;      // 0 random, 1 ready high, 2 ready low
    logic          auto_gen;
    // slave responder
    logic          s_all_rdy, s_fixed;
    int            s_lat;        // <0: random 0..3
    logic          s_rd_busy, s_rvalid, s_aw_got, s_w_got, s_bvalid;
    int            s_rd_cnt;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp, s_bresp;
    // reference model: one transaction record
    logic          md_busy, md_g, md_wr, md_last, md_a_done, md_aw_done, md_w_done;
    logic [31:0]   md_addr, md_wdata;
    logic [3:0]    md_wstrb;
    // snapshots of the last sampled cycle
    logic          sn_arr0, sn_arr1, sn_awr1, sn_wr1, sn_rv0, sn_rr0, sn_bv1, sn_br1, sn_arv_s;
    logic [31:0]   sn_rdata0, sn_araddr;
    logic [1:0]    sn_rresp0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [14:0] dut_ctl();
        return {ARREADY_M0, ARREADY_M1, AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1,
                RVALID_M0, RVALID_M1, BVALID_M0, BVALID_M1,
                ARVALID_S, RREADY_S, AWVALID_S, WVALID_S, BREADY_S};
    endfunction

    function automatic logic rdy();
        if (rr_mode == 0) return 1'($urandom_range(0, 1));
        return rr_mode == 1;
    endfunction

    function automatic logic srdy();
        if (s_all_rdy) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive();
        ARVALID_M0 = m_rd[0]; ARADDR_M0 = m_ra[0];
        AWVALID_M0 = m_wr[0]; WVALID_M0 = m_wr[0]; AWADDR_M0 = m_wa[0];
        WDATA_M0 = m_wd[0]; WSTRB_M0 = m_ws[0];
        ARVALID_M1 = m_rd[1]; ARADDR_M1 = m_ra[1];
        AWVALID_M1 = m_wr[1]; WVALID_M1 = m_wr[1]; AWADDR_M1 = m_wa[1];
        WDATA_M1 = m_wd[1]; WSTRB_M1 = m_ws[1];
        RREADY_M0 = rdy(); RREADY_M1 = rdy(); BREADY_M0 = rdy(); BREADY_M1 = rdy();
        ARREADY_S = srdy(); AWREADY_S = srdy(); WREADY_S = srdy();
        RVALID_S = s_rvalid;
        RDATA_S  = s_rvalid ? s_rdata : $urandom;
        RRESP_S  = s_rvalid ? s_rresp : 2'($urandom_range(0, 3));
        BVALID_S = s_bvalid;
        BRESP_S  = s_bvalid ? s_bresp : 2'($urandom_range(0, 3));
    endtask

    task automatic reset_slave_model();
        s_rd_busy = 0; s_rvalid = 0; s_aw_got = 0; s_w_got = 0; s_bvalid = 0; s_rd_cnt = 0;
        md_busy = 0; md_last = 1; md_g = 0; md_wr = 0;
        md_a_done = 0; md_aw_done = 0; md_w_done = 0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance model and stimulus.
    task automatic cycle();
        logic e_arr0, e_arr1, e_awr0, e_awr1, e_rv0, e_rv1, e_bv0, e_bv1;
        logic e_arv_s, e_rr_s, e_awv_s, e_wv_s, e_br_s;
        logic rd0, rd1, wr0, wr1, w, sw, rr, br;
        logic g_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
        @(negedge ACLK);
        {e_arr0, e_arr1, e_awr0, e_awr1, e_rv0, e_rv1, e_bv0, e_bv1} = '0;
        {e_arv_s, e_rr_s, e_awv_s, e_wv_s, e_br_s} = '0;
        {g_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs} = '0;
        w = 0; sw = 0;
        rd0 = ARVALID_M0; rd1 = ARVALID_M1;
        wr0 = AWVALID_M0 & WVALID_M0; wr1 = AWVALID_M1 & WVALID_M1;
        if (!md_busy) begin
            if (rd0 || wr0 || rd1 || wr1) begin
                if ((rd0 || wr0) && (rd1 || wr1)) w = (FIXED != 0) ? 1'b1 : (md_last ? 1'b0 : 1'b1);
                else w = rd1 || wr1;
                sw = w ? wr1 : wr0;
                g_hs = 1;
                if (sw) begin
                    if (w) e_awr1 = 1; else e_awr0 = 1;
                end else begin
                    if (w) e_arr1 = 1; else e_arr0 = 1;
                end
            end
        end else if (!md_wr) begin
            if (!md_a_done) begin
                e_arv_s = 1;
                chk("araddr_s", ARADDR_S, md_addr);
                ar_hs = ARREADY_S;
            end else begin
                rr = md_g ? RREADY_M1 : RREADY_M0;
                e_rr_s = rr;
                if (md_g) e_rv1 = RVALID_S; else e_rv0 = RVALID_S;
                chk("rdata_fwd", md_g ? RDATA_M1 : RDATA_M0, RDATA_S);
                chk("rresp_fwd", md_g ? RRESP_M1 : RRESP_M0, RRESP_S);
                r_hs = RVALID_S & rr;
            end
        end else if (!(md_aw_done && md_w_done)) begin
            e_awv_s = !md_aw_done;
            e_wv_s  = !md_w_done;
            if (e_awv_s) chk("awaddr_s", AWADDR_S, md_addr);
            if (e_wv_s) begin
                chk("wdata_s", WDATA_S, md_wdata);
                chk("wstrb_s", WSTRB_S, md_wstrb);
            end
            aw_hs = e_awv_s & AWREADY_S;
            w_hs  = e_wv_s & WREADY_S;
        end else begin
            br = md_g ? BREADY_M1 : BREADY_M0;
            e_br_s = br;
            if (md_g) e_bv1 = BVALID_S; else e_bv0 = BVALID_S;
            chk("bresp_fwd", md_g ? BRESP_M1 : BRESP_M0, BRESP_S);
            b_hs = BVALID_S & br;
        end
        chk("ctl", dut_ctl(), {e_arr0, e_arr1, e_awr0, e_awr1, e_awr0, e_awr1,
                               e_rv0, e_rv1, e_bv0, e_bv1, e_arv_s, e_rr_s, e_awv_s, e_wv_s, e_br_s});
        sn_arr0 = ARREADY_M0; sn_arr1 = ARREADY_M1; sn_awr1 = AWREADY_M1; sn_wr1 = WREADY_M1;
        sn_rv0 = RVALID_M0; sn_rr0 = RREADY_M0; sn_bv1 = BVALID_M1; sn_br1 = BREADY_M1;
        sn_arv_s = ARVALID_S; sn_rdata0 = RDATA_M0; sn_rresp0 = RRESP_M0; sn_araddr = ARADDR_S;

        @(posedge ACLK);
        if (g_hs) begin
            md_busy = 1; md_g = w; md_wr = sw; md_last = w;
            md_addr = sw ? m_wa[w] : m_ra[w];
            md_wdata = m_wd[w]; md_wstrb = m_ws[w];
            md_a_done = 0; md_aw_done = 0; md_w_done = 0;
            if (sw) m_wr[w] = 0; else m_rd[w] = 0;
        end
        if (ar_hs) md_a_done = 1;
        if (aw_hs) md_aw_done = 1;
        if (w_hs) md_w_done = 1;
        if (r_hs || b_hs) md_busy = 0;

        if (r_hs) begin
            s_rvalid = 0; s_rd_busy = 0;
        end else if (s_rd_busy && !s_rvalid) begin
            if (s_rd_cnt == 0) begin
                s_rvalid = 1;
                s_rdata  = s_fixed ? 32'hDEAD_BEEF : $urandom;
                s_rresp  = s_fixed ? 2'b00 : 2'($urandom_range(0, 3));
            end else s_rd_cnt--;
        end
        if (ar_hs) begin
            s_rd_busy = 1;
            s_rd_cnt  = (s_lat < 0) ? int'($urandom_range(0, 3)) : s_lat;
        end
        if (b_hs) begin
            s_bvalid = 0; s_aw_got = 0; s_w_got = 0;
        end else if (s_aw_got && s_w_got && !s_bvalid) begin
            s_bvalid = 1; s_bresp = 2'($urandom_range(0, 3));
        end
        if (aw_hs) s_aw_got = 1;
        if (w_hs) s_w_got = 1;

        if (auto_gen) begin
            for (int x = 0; x < 2; x++) begin
                if (!m_rd[x] && $urandom_range(0, 3) == 0) begin
                    m_rd[x] = 1; m_ra[x] = $urandom & 32'hFFFF_FFFC;
                end
                if (!m_wr[x] && $urandom_range(0, 3) == 0) begin
                    m_wr[x] = 1; m_wa[x] = $urandom & 32'hFFFF_FFFC;
                    m_wd[x] = $urandom; m_ws[x] = 4'($urandom_range(0, 15));
                end
            end
        end
        #1;
        drive();
        cyc++;
    endtask

    task automatic do_reset(input int n);
        ARESET = 1;
        #1;
        chk("rst_ctl", dut_ctl(), 15'd0);
        reset_slave_model();
        drive();
        repeat (n) @(posedge ACLK);
        #1;
        chk("rst_ctl_hold", dut_ctl(), 15'd0);
        ARESET = 0;
    endtask

    task automatic drain();
        auto_gen = 0;
        for (int i = 0; i < 300 && (md_busy || m_rd[0] || m_rd[1] || m_wr[0] || m_wr[1]); i++) cycle();
        chk("drain_idle", {md_busy, m_rd[0], m_rd[1], m_wr[0], m_wr[1]}, 0);
    endtask

    initial begin
        int k_ar, k_sv, n_ar, ng;
        logic done, got, bdone;
        logic [1:0] seq[4];
        for (int x = 0; x < 2; x++) begin
            m_rd[x] = 1; m_wr[x] = 1; m_ra[x] = 0; m_wa[x] = 0; m_wd[x] = 0; m_ws[x] = 0;
        end
        rr_mode = 1; auto_gen = 0; s_all_rdy = 1; s_fixed = 1; s_lat = 0;
        s_rdata = 0; s_rresp = 0; s_bresp = 0;
        reset_slave_model();
        drive();
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_por_ctl", dut_ctl(), 15'd0);
        for (int x = 0; x < 2; x++) begin m_rd[x] = 0; m_wr[x] = 0; end
        do_reset(1);

        // single M0 read, slave answers DEADBEEF/OKAY after a few cycles
        s_lat = 3; m_rd[0] = 1; m_ra[0] = 32'h0000_0010; drive();
        k_ar = -1; k_sv = -1; n_ar = 0; done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            cycle();
            if (sn_arr0) begin n_ar++; k_ar = i; end
            if (sn_arv_s && k_sv < 0) begin k_sv = i; chk("t1_araddr", sn_araddr, 32'h10); end
            if (sn_rv0 && sn_rr0) begin
                done = 1;
                chk("t1_rdata", sn_rdata0, 32'hDEAD_BEEF);
                chk("t1_rresp", sn_rresp0, 2'b00);
            end
        end
        chk("t1_done", done, 1);
        chk("t1_arready_pulses", n_ar, 1);
        chk("t1_arvalid_lag", k_sv - k_ar, 1);
        drain();

        // both masters hold ARVALID from reset: alternate grants
        do_reset(1);
        s_lat = 0; ng = 0;
        m_rd[0] = 1; m_rd[1] = 1; m_ra[0] = 32'h100; m_ra[1] = 32'h200; drive();
        for (int i = 0; i < 80 && ng < 4; i++) begin
            cycle();
            if (sn_arr0) begin seq[ng] = 0; ng++; end
            else if (sn_arr1) begin seq[ng] = 1; ng++; end
            if (ng < 3) begin m_rd[0] = 1; m_rd[1] = 1; drive(); end
        end
        chk("t2_grants", ng, 4);
        chk("t2_grant0", seq[0], (FIXED != 0) ? 1 : 0);
        chk("t2_grant1", seq[1], 1);
        chk("t2_grant2", seq[2], (FIXED != 0) ? 1 : 0);
        chk("t2_grant3", seq[3], 1);
        drain();

        // M1 read and write together: write goes first
        m_rd[1] = 1; m_ra[1] = 32'h0000_0300;
        m_wr[1] = 1; m_wa[1] = 32'h0000_0100; m_wd[1] = 32'h1234_5678; m_ws[1] = 4'h3;
        s_all_rdy = 0; drive();
        cycle();
        chk("t4_awready", {sn_awr1, sn_wr1, sn_arr1}, 3'b110);
        got = 0; bdone = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            cycle();
            if (sn_bv1 && sn_br1) bdone = 1;
            if (sn_arr1) got = 1;
        end
        chk("t4_read_granted", got, 1);
        chk("t4_write_first", bdone, 1);
        drain();

        // backpressure in read data, then reset while the read is stuck
        s_all_rdy = 1; s_lat = 2; rr_mode = 2;
        m_rd[0] = 1; m_ra[0] = 32'h0000_0040; drive();
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            cycle();
            if (sn_arr0) begin m_rd[1] = 1; m_ra[1] = 32'h0000_0080; drive(); end
            if (sn_rv0) done = 1;
        end
        chk("t5_rvalid_seen", done, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t5_held_rvalid", sn_rv0, 1);
            chk("t5_rdata_stable", sn_rdata0, s_rdata);
            chk("t5_m1_blocked", sn_arr1, 0);
        end
        do_reset(1);
        rr_mode = 1; drive();
        cycle();
        chk("t6_m1_grant", sn_arr1, 1);
        drain();

        // randomized traffic
        do_reset(2);
        auto_gen = 1; rr_mode = 0; s_all_rdy = 0; s_lat = -1; s_fixed = 0;
        repeat (3000) cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
